// File: rtl/if_fetch_stage_if.sv
// Instruction-cache request/response bundle between the fetch stage (master)
// and the instruction cache (slave); request and response are independent handshakes.
interface if_fetch_stage_if #(
    parameter int ADDR_W  = 16,
    parameter int INSTR_W = 32
);
    logic               icache_req_o;
    logic [ADDR_W-1:0]  icache_addr_o;
    logic               icache_ready_i;
    logic               icache_valid_i;
    logic [INSTR_W-1:0] icache_rdata_i;

    modport master (
        output icache_req_o,
        output icache_addr_o,
        input  icache_ready_i,
        input  icache_valid_i,
        input  icache_rdata_i
    );

    modport slave (
        input  icache_req_o,
        input  icache_addr_o,
        output icache_ready_i,
        output icache_valid_i,
        output icache_rdata_i
    );
endinterface

// File: rtl/if_fetch_stage.sv
// RV32I instruction-fetch stage: owns the PC, keeps one i-cache read in flight
// and drives the IF/ID register, honouring decode stalls and execute redirects.
module if_fetch_stage #(
    parameter int                 ADDR_W    = 16,
    parameter int                 INSTR_W   = 32,
    parameter logic [ADDR_W-1:0]  RESET_PC  = '0,
    parameter logic [INSTR_W-1:0] NOP_INSTR = 32'h0000_0013
) (
    input  logic               clk_i,
    input  logic               rst_ni,
    input  logic               stall_i,
    input  logic               redirect_i,
    input  logic [ADDR_W-1:0]  redirect_pc_i,
    if_fetch_stage_if.master   icache,
    output logic               if_valid_o,
    output logic [ADDR_W-1:0]  if_pc_o,
    output logic [ADDR_W-1:0]  if_pc4_o,
    output logic [INSTR_W-1:0] if_instr_o,
    output logic               fetch_busy_o,
    output logic [1:0]         dbg_state_o
);

    // Handshake: a request is accepted on a rising edge where icache_req_o and
    // icache_ready_i are both 1; the answer is the first later edge with icache_valid_i=1.
    typedef enum logic [1:0] {
        S_REQ  = 2'd0,
        S_WAIT = 2'd1,
        S_HOLD = 2'd2,
        S_DROP = 2'd3
    } state_e;

    state_e             state_q, state_d;
    logic [ADDR_W-1:0]  pc_q, pc_d;
    logic [INSTR_W-1:0] hold_q, hold_d;
    logic               valid_q, valid_d;
    logic [ADDR_W-1:0]  if_pc_q, if_pc_d;
    logic [ADDR_W-1:0]  if_pc4_q, if_pc4_d;
    logic [INSTR_W-1:0] instr_q, instr_d;

    logic               load;
    logic [INSTR_W-1:0] load_instr;
    logic [ADDR_W-1:0]  pc_plus4;

    assign pc_plus4 = pc_q + ADDR_W'(4);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q  <= S_REQ;
            pc_q     <= RESET_PC;
            hold_q   <= '0;
            valid_q  <= 1'b0;
            if_pc_q  <= '0;
            if_pc4_q <= '0;
            instr_q  <= NOP_INSTR;
        end else begin
            state_q  <= state_d;
            pc_q     <= pc_d;
            hold_q   <= hold_d;
            valid_q  <= valid_d;
            if_pc_q  <= if_pc_d;
            if_pc4_q <= if_pc4_d;
            instr_q  <= instr_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        hold_d     = hold_q;
        valid_d    = stall_i ? valid_q : 1'b0;
        if_pc_d    = if_pc_q;
        if_pc4_d   = if_pc4_q;
        instr_d    = instr_q;
        load       = 1'b0;
        load_instr = '0;

        if (redirect_i) begin
            // Flush beats stall; a read still in flight must be swallowed in DROP.
            pc_d    = {redirect_pc_i[ADDR_W-1:2], 2'b00};
            valid_d = 1'b0;
            instr_d = NOP_INSTR;
            hold_d  = '0;
            if ((state_q == S_WAIT || state_q == S_DROP) && !icache.icache_valid_i) begin
                state_d = S_DROP;
            end else begin
                state_d = S_REQ;
            end
        end else begin
            case (state_q)
                S_REQ: begin
                    if (icache.icache_ready_i) state_d = S_WAIT;
                end
                S_WAIT: begin
                    if (icache.icache_valid_i) begin
                        if (stall_i) begin
                            hold_d  = icache.icache_rdata_i;
                            state_d = S_HOLD;
                        end else begin
                            load       = 1'b1;
                            load_instr = icache.icache_rdata_i;
                            state_d    = S_REQ;
                        end
                    end
                end
                S_HOLD: begin
                    if (!stall_i) begin
                        load       = 1'b1;
                        load_instr = hold_q;
                        state_d    = S_REQ;
                    end
                end
                S_DROP: begin
                    if (icache.icache_valid_i) state_d = S_REQ;
                end
                default: state_d = S_REQ;
            endcase

            if (load) begin
                if_pc_d  = pc_q;
                if_pc4_d = pc_plus4;
                instr_d  = load_instr;
                valid_d  = 1'b1;
                pc_d     = pc_plus4;
            end
        end
    end

    assign icache.icache_req_o  = (state_q == S_REQ) && rst_ni && !redirect_i;
    assign icache.icache_addr_o = pc_q;

    assign if_valid_o   = valid_q;
    assign if_pc_o      = if_pc_q;
    assign if_pc4_o     = if_pc4_q;
    assign if_instr_o   = instr_q;
    assign fetch_busy_o = (state_q == S_WAIT) || (state_q == S_DROP);
    assign dbg_state_o  = state_q;

endmodule

// File: doc/if_fetch_stage.md
Name: if_fetch_stage

Overview:
Instruction-fetch stage of the pipelined RV32I core. It owns the program counter (PC) and issues one instruction-cache read at a time. It produces the PC+4 link value and drives the IF/ID pipeline register (PC, PC+4, instruction, valid) consumed by decode. It honours hazard-unit stalls and branch/jump redirects from execute.

Parameters:
ADDR_W, 16, width of PC and instruction-cache address
INSTR_W, 32, instruction width
RESET_PC, 16'h0000, PC value loaded on reset
NOP_INSTR, 32'h0000_0013, instruction driven on if_instr_o when no valid instruction is held (addi x0,x0,0)

Ports:
clk_i  in  1  clock; all state updates on its rising edge
rst_ni  in  1  asynchronous active-low reset
stall_i  in  1  hazard-unit stall; freezes all IF/ID outputs
redirect_i  in  1  taken branch/jump from execute
redirect_pc_i  in  ADDR_W  redirect target
icache_req_o  out  1  read request to instruction cache
icache_addr_o  out  ADDR_W  request address; equals current PC
icache_ready_i  in  1  cache accepts the request this cycle
icache_valid_i  in  1  read data valid
icache_rdata_i  in  INSTR_W  read data
if_valid_o  out  1  IF/ID register holds a real instruction
if_pc_o  out  ADDR_W  PC of the held instruction
if_pc4_o  out  ADDR_W  if_pc_o + 4
if_instr_o  out  INSTR_W  held instruction
fetch_busy_o  out  1  a request is outstanding (state WAIT or DROP)

Behaviour:
- Reset (asynchronous, rst_ni=0), effective immediately:
  - pc=RESET_PC, state=REQ.
  - if_valid_o=0, if_pc_o=0, if_pc4_o=0, if_instr_o=NOP_INSTR.
  - icache_req_o=0, fetch_busy_o=0.
  - Hold buffer cleared.
- icache_req_o=1 only in state REQ with rst_ni=1 and redirect_i=0. icache_addr_o=pc in every state.
- At most one request outstanding. Request and response are separate handshakes. A response may arrive at the earliest one cycle after acceptance.
- FSM:
  - REQ: if icache_ready_i=1, go to WAIT; otherwise stay in REQ with the request held stable.
  - WAIT: on icache_valid_i=1:
    - stall_i=0: load IF/ID with {pc, pc+4, rdata}, set if_valid_o=1, set pc<=pc+4, go to REQ.
    - stall_i=1: capture rdata in the hold buffer and go to HOLD.
  - HOLD: when stall_i=0, load IF/ID from the hold buffer, set if_valid_o=1, set pc<=pc+4, go to REQ.
  - DROP: on icache_valid_i=1, discard the data and go to REQ.
- Redirect has the highest priority, above stall_i, in every state:
  - pc<=redirect_pc_i with bits [1:0] forced to 00.
  - if_valid_o<=0 and if_instr_o<=NOP_INSTR (flush); if_pc_o and if_pc4_o hold.
  - Next state: DROP if a request is outstanding (WAIT without icache_valid_i, or REQ with icache_ready_i sampled in the same cycle). Otherwise REQ. Redirect in HOLD discards the buffer.
  - Since icache_req_o=0 while redirect_i=1, REQ-with-ready cannot occur; a redirect out of REQ always goes to REQ.
  - Redirect coinciding with icache_valid_i in WAIT: the data is discarded and the next state is REQ.
- Stall, with no redirect: if_valid_o, if_pc_o, if_pc4_o and if_instr_o hold. PC and FSM still advance as listed above.
- Bubble: a cycle with stall_i=0, no redirect and no load sets if_valid_o<=0. if_pc_o, if_pc4_o and if_instr_o hold.
- Arithmetic: pc+4 and if_pc4_o are modulo 2^ADDR_W, so 16'hFFFC wraps to 16'h0000. No carry or overflow is reported.
- Minimum latency: request accepted in cycle N, data returned in N+1, if_valid_o=1 in N+2. Peak throughput is one instruction per 2 cycles.
- Mid-operation reset: any state returns to reset values immediately. Any late cache response after reset release is ignored unless state=WAIT.

Test Plan:
1. Reset then release, icache_ready_i=1, one-cycle data latency, rdata = 32'h00500093, 32'h00100113 → the first IF/ID load has if_pc_o=0000, if_pc4_o=0004, if_instr_o=00500093, if_valid_o=1 two cycles after the request. The second load has if_pc_o=0004, if_pc4_o=0008.
2. icache_ready_i=0 for 3 cycles with PC=0008 → icache_req_o stays 1 and icache_addr_o stays 0008 all 3 cycles. IF/ID is unchanged with if_valid_o=0 after the first bubble.
3. stall_i=1 when data 32'hDEADBEEF returns at PC=000C → outputs freeze and the FSM goes to HOLD. After stall_i drops, the next edge gives if_instr_o=DEADBEEF, if_pc_o=000C, pc=0010.
4. redirect_i=1, redirect_pc_i=0x0123, while in WAIT → pc=0120, if_valid_o=0, if_instr_o=00000013. The late response is dropped. The next icache_addr_o is 0120, and the first valid output has if_pc_o=0120.
5. PC=FFFC, response arrives → if_pc4_o=0000 and the next request has icache_addr_o=0000.
6. Pull rst_ni low mid-WAIT without a clock edge → outputs reach reset values asynchronously. A response arriving after release is ignored, and the first request is issued to RESET_PC.
